// File: rtl/dsp_simd_seg_comp_pipe.sv
// SIMD segment compensation for packed DSP products.
// Each packed lane k>=1 is biased by the sign (MSB) of lane k-1. That bit is
// added back into lane k. The datapath is a two-stage valid/ready pipeline
// with a global clock enable.

// Per-lane compensation: add carry-in, flag/resolve the single overflow case.
module dsp_simd_seg_lane #(
  parameter int SEG_W = 18,
  parameter bit SAT   = 1'b0
) (
  input  logic [SEG_W-1:0] raw,
  input  logic             cin,
  output logic [SEG_W-1:0] comp,
  output logic             ovf
);
  localparam logic [SEG_W-1:0] MAX_V = {1'b0, {(SEG_W-1){1'b1}}};
  localparam logic [SEG_W-1:0] MIN_V = {1'b1, {(SEG_W-1){1'b0}}};

  // Only +max with carry-in can overflow a signed +0/+1 increment.
  always_comb begin
    ovf  = cin && (raw == MAX_V);
    comp = raw + {{(SEG_W-1){1'b0}}, cin};
    if (ovf) comp = SAT ? MAX_V : MIN_V;
  end
endmodule

module dsp_simd_seg_comp_pipe #(
  parameter int    LANES  = 2,
  parameter int    SEG_W  = 18,
  parameter int    IN_W   = 48,
  parameter string SAT_EN = "false"
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   clken,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_W-1:0]        dsp_data_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*SEG_W-1:0] seg_out,
  output logic [LANES-1:0]       seg_ovf
);
  localparam int W   = LANES * SEG_W;
  localparam bit SAT = (SAT_EN == "true");

  if (LANES < 2 || LANES > 4 || W > IN_W) begin : g_param_err
    $error("dsp_simd_seg_comp_pipe: illegal LANES/SEG_W/IN_W combination");
  end

  // [1] = S1 holds a raw word, [2] = S2 holds a result (out_valid)
  logic [2:1]       vld_pipe_q, vld_pipe_d;
  logic [W-1:0]     s1_data_q, s1_data_d;
  logic [W-1:0]     seg_out_q, seg_out_d;
  logic [LANES-1:0] seg_ovf_q, seg_ovf_d;
  logic [W-1:0]     comp;
  logic [LANES-1:0] ovf;
  logic             s1_adv, s2_adv;
  logic             unused_in_bits;

  // Upper bits beyond the packed lanes carry no lane data.
  assign unused_in_bits = ^dsp_data_in;

  assign s2_adv = clken && (!vld_pipe_q[2] || out_ready);
  assign s1_adv = clken && (!vld_pipe_q[1] || s2_adv);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic cin;
    if (k == 0) begin : g_first
      assign cin = 1'b0;
    end else begin : g_rest
      assign cin = s1_data_q[k*SEG_W-1];
    end
    dsp_simd_seg_lane #(.SEG_W(SEG_W), .SAT(SAT)) u_lane (
      .raw  (s1_data_q[k*SEG_W +: SEG_W]),
      .cin  (cin),
      .comp (comp[k*SEG_W +: SEG_W]),
      .ovf  (ovf[k])
    );
  end

  // Next-state: each stage loads only when it advances; data only on valid.
  always_comb begin
    vld_pipe_d = vld_pipe_q;
    s1_data_d  = s1_data_q;
    seg_out_d  = seg_out_q;
    seg_ovf_d  = seg_ovf_q;
    if (s1_adv) begin
      vld_pipe_d[1] = in_valid;
      if (in_valid) s1_data_d = dsp_data_in[W-1:0];
    end
    if (s2_adv) begin
      vld_pipe_d[2] = vld_pipe_q[1];
      if (vld_pipe_q[1]) begin
        seg_out_d = comp;
        seg_ovf_d = ovf;
      end
    end
  end

  // Pipeline registers; reset drops any beats in flight.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      vld_pipe_q <= '0;
      s1_data_q  <= '0;
      seg_out_q  <= '0;
      seg_ovf_q  <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s1_data_q  <= s1_data_d;
      seg_out_q  <= seg_out_d;
      seg_ovf_q  <= seg_ovf_d;
    end
  end

  assign in_ready  = s1_adv;
  assign out_valid = vld_pipe_q[2];
  assign seg_out   = seg_out_q;
  assign seg_ovf   = seg_ovf_q;
endmodule

// File: tb/tb_dsp_simd_seg_comp_pipe.sv
// Directed bench: scoreboard for the default build, plus a saturating
// instance and a 3-lane/16-bit instance for fixed-vector checks.
module tb_dsp_simd_seg_comp_pipe;
  logic        clk, aresetn, clken;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [47:0] dsp_data_in;
  logic [35:0] seg_out;
  logic [1:0]  seg_ovf;

  logic        s_in_valid, s_in_ready, s_out_valid;
  logic [47:0] s_data;
  logic [35:0] s_seg_out;
  logic [1:0]  s_seg_ovf;

  logic        t_in_valid, t_in_ready, t_out_valid;
  logic [47:0] t_data;
  logic [47:0] t_seg_out;
  logic [2:0]  t_seg_ovf;

  int vectors = 0;
  int miscompares = 0;

  logic [37:0] sb[$];
  logic [37:0] e, hold_val;
  bit          hold_chk, acc, last_rdy;

  dsp_simd_seg_comp_pipe dut (
    .clk(clk), .aresetn(aresetn), .clken(clken),
    .in_valid(in_valid), .in_ready(in_ready), .dsp_data_in(dsp_data_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .seg_out(seg_out), .seg_ovf(seg_ovf)
  );

  dsp_simd_seg_comp_pipe #(.SAT_EN("true")) dut_sat (
    .clk(clk), .aresetn(aresetn), .clken(clken),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .dsp_data_in(s_data),
    .out_valid(s_out_valid), .out_ready(1'b1),
    .seg_out(s_seg_out), .seg_ovf(s_seg_ovf)
  );

  dsp_simd_seg_comp_pipe #(.LANES(3), .SEG_W(16)) dut_l3 (
    .clk(clk), .aresetn(aresetn), .clken(clken),
    .in_valid(t_in_valid), .in_ready(t_in_ready), .dsp_data_in(t_data),
    .out_valid(t_out_valid), .out_ready(1'b1),
    .seg_out(t_seg_out), .seg_ovf(t_seg_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference for the default build: signed lane1 + sign of lane0, wrap on overflow.
  function automatic logic [37:0] model(input logic [47:0] d);
    logic [17:0] r0, r1;
    int          v;
    logic        o;
    r0 = d[17:0];
    r1 = d[35:18];
    v  = int'($signed(r1)) + int'(r0[17]);
    o  = (v > 131071);
    if (o) v = -131072;
    return {v[17:0], r0, o, 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge (hold check, accept -> push, transfer -> pop).
  task automatic cyc();
    @(negedge clk);
    if (hold_chk) begin
      chk("hold_valid", 64'(out_valid), 64'(1));
      chk("hold_data", 64'({seg_out, seg_ovf}), 64'(hold_val));
    end
    hold_chk = out_valid && !(out_ready && clken) && aresetn;
    hold_val = {seg_out, seg_ovf};
    last_rdy = in_ready;
    acc = in_valid && in_ready && aresetn;
    if (acc) sb.push_back(model(dsp_data_in));
    if (out_valid && out_ready && clken && aresetn) begin
      if (sb.size() == 0) chk("extra_beat", 64'(out_valid), 64'(0));
      else begin
        e = sb.pop_front();
        chk("beat", 64'({seg_out, seg_ovf}), 64'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  n, c;
    bit  saw_nr;
    aresetn = 1'b1; clken = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    dsp_data_in = '0; s_in_valid = 1'b0; s_data = '0; t_in_valid = 1'b0; t_data = '0;
    hold_chk = 1'b0;
    #2 aresetn = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_seg_out", 64'(seg_out), 64'(0));
    chk("rst_seg_ovf", 64'(seg_ovf), 64'(0));
    chk("rst_sat_valid", 64'(s_out_valid), 64'(0));
    @(posedge clk); #1;
    aresetn = 1'b1;
    chk("rdy_after_rst", 64'(in_ready), 64'(clken));

    // Basic compensation and 2-cycle latency
    dsp_data_in = {12'h000, 18'h00005, 18'h20000};
    in_valid = 1'b1;
    cyc();
    chk("a_accept", 64'(acc), 64'(1));
    in_valid = 1'b0;
    chk("a_lat1", 64'(out_valid), 64'(0));
    cyc();
    chk("a_lat2", 64'(out_valid), 64'(1));
    chk("a_value", 64'({seg_out, seg_ovf}), 64'({18'h00006, 18'h20000, 2'b00}));
    cyc();

    // Overflow wrap (default), saturate instance, 3-lane instance; junk high bits
    dsp_data_in = {12'hABC, 18'h1FFFF, 18'h20000};
    s_data      = {12'h000, 18'h1FFFF, 18'h20000};
    t_data      = {16'h0001, 16'hFFFF, 16'h8000};
    in_valid = 1'b1; s_in_valid = 1'b1; t_in_valid = 1'b1;
    cyc();
    in_valid = 1'b0; s_in_valid = 1'b0; t_in_valid = 1'b0;
    cyc();
    chk("b_wrap", 64'({seg_out, seg_ovf}), 64'({18'h20000, 18'h20000, 2'b10}));
    chk("b_sat_valid", 64'(s_out_valid), 64'(1));
    chk("b_sat", 64'({s_seg_out, s_seg_ovf}), 64'({18'h1FFFF, 18'h20000, 2'b10}));
    chk("b_l3_valid", 64'(t_out_valid), 64'(1));
    chk("b_l3", 64'({t_seg_out, t_seg_ovf}), 64'({16'h0002, 16'h0000, 16'h8000, 3'b000}));
    chk("b_side_rdy", 64'({s_in_ready, t_in_ready}), 64'(2'b11));
    cyc();

    // 8 back-to-back beats with out_ready low for cycles 3..6
    n = 0; c = 0; saw_nr = 1'b0;
    in_valid = 1'b1;
    dsp_data_in = 48'({$urandom, $urandom});
    while (n < 8 && c < 40) begin
      out_ready = !(c >= 3 && c <= 6);
      cyc();
      if (!last_rdy) saw_nr = 1'b1;
      if (acc) begin
        n++;
        dsp_data_in = (n == 2) ? {12'h0, 18'h1FFFF, 18'h3FFFF} : 48'({$urandom, $urandom});
      end
      c++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("c_all_in", 64'(n), 64'(8));
    chk("c_backpressure", 64'(saw_nr), 64'(1));
    for (int i = 0; i < 10 && sb.size() != 0; i++) cyc();
    chk("c_drained", 64'(sb.size()), 64'(0));

    // clken low for 3 cycles with a pending output
    out_ready = 1'b0;
    dsp_data_in = 48'({$urandom, $urandom});
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    chk("d_pending", 64'(out_valid), 64'(1));
    clken = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("d_rdy_low", 64'(in_ready), 64'(0));
      chk("d_frozen_valid", 64'(out_valid), 64'(1));
    end
    clken = 1'b1;
    cyc();
    chk("d_delivered", 64'(sb.size()), 64'(0));
    chk("d_after", 64'(out_valid), 64'(0));

    // Reset with two beats in flight: both must vanish
    out_ready = 1'b0;
    in_valid = 1'b1;
    dsp_data_in = 48'({$urandom, $urandom});
    cyc();
    dsp_data_in = 48'({$urandom, $urandom});
    cyc();
    in_valid = 1'b0;
    chk("e_inflight", 64'(out_valid), 64'(1));
    aresetn = 1'b0; hold_chk = 1'b0;
    #1;
    chk("e_rst_valid", 64'(out_valid), 64'(0));
    chk("e_rst_data", 64'({seg_out, seg_ovf}), 64'(0));
    sb.delete();
    cyc();
    aresetn = 1'b1;
    chk("e_rdy", 64'(in_ready), 64'(clken));
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    chk("e_no_beat", 64'(out_valid), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
